// File: rtl/msi_cfg_reader.sv
// MSI capability reader: after an enable edge or refresh, settles, then walks the MSI
// capability dwords over the config read port with a per-read timeout and bounded retries.
module msi_cfg_reader #(
  parameter logic [9:0]  MSI_CAP_BASE  = 10'h022,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned TIMEOUT_W     = 9,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter logic [63:0] DEF_ADDR      = 64'h00000000_FEEFF00C,
  parameter logic [15:0] DEF_DATA      = 16'h4162
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic        cfg_interrupt_msienable,
  input  logic        refresh,
  output logic [9:0]  cfg_dwaddr,
  output logic        cfg_rd_en_n,
  input  logic [31:0] cfg_do,
  input  logic        cfg_rd_wr_done_n,
  output logic [63:0] msi_message_addr_reg,
  output logic [15:0] msi_message_data_reg,
  output logic [2:0]  msi_mme,
  output logic        msi_valid,
  output logic        msi_busy,
  output logic        msi_error
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [1:0]  IDX_CTRL    = 2'd0;
  localparam logic [1:0]  IDX_ALO     = 2'd1;
  localparam logic [1:0]  IDX_AHI     = 2'd2;
  localparam logic [1:0]  IDX_DATA    = 2'd3;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_t               r_state, w_next;
  logic                 r_en_q, r_armed;
  logic [15:0]          r_settle_cnt;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [3:0]           r_retry;
  logic [1:0]           r_idx;
  logic                 r_is64;
  logic [9:0]           r_dwaddr;
  logic [63:0]          r_addr;
  logic [15:0]          r_data;
  logic [2:0]           r_mme;
  logic                 r_error;

  logic       w_start, w_done, w_to_term, w_capture, w_retry, w_enter;
  logic [1:0] w_idx_nxt, w_issue_idx;
  logic [9:0] w_issue_addr;

  // Armed only once enable has been seen low, so a level held through reset is not an edge.
  assign w_start   = r_armed & cfg_interrupt_msienable & (~r_en_q | refresh);
  assign w_done    = ~cfg_rd_wr_done_n;
  assign w_to_term = &r_to_cnt;
  assign w_enter   = (w_next == S_SETTLE) && (r_state != S_SETTLE);

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_retry   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          w_capture = 1'b1;
          w_next    = (r_idx == IDX_DATA) ? S_DONE : S_ISSUE;
        end else if (w_to_term) begin
          if (r_retry < RETRY_MAX) begin
            w_retry = 1'b1;
            w_next  = S_ISSUE;
          end else begin
            w_next = S_ERR;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (!cfg_interrupt_msienable) begin
      w_next    = S_IDLE;
      w_capture = 1'b0;
      w_retry   = 1'b0;
    end
  end

  always_comb begin
    w_idx_nxt = IDX_DATA;
    case (r_idx)
      IDX_CTRL: w_idx_nxt = IDX_ALO;
      IDX_ALO:  w_idx_nxt = r_is64 ? IDX_AHI : IDX_DATA;
      default:  w_idx_nxt = IDX_DATA;
    endcase
    w_issue_idx = r_idx;
    if (r_state == S_SETTLE) w_issue_idx = IDX_CTRL;
    else if (w_capture)      w_issue_idx = w_idx_nxt;
    case (w_issue_idx)
      IDX_CTRL: w_issue_addr = MSI_CAP_BASE;
      IDX_ALO:  w_issue_addr = MSI_CAP_BASE + 10'd1;
      IDX_AHI:  w_issue_addr = MSI_CAP_BASE + 10'd2;
      default:  w_issue_addr = MSI_CAP_BASE + (r_is64 ? 10'd3 : 10'd2);
    endcase
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_en_q       <= 1'b0;
      r_armed      <= 1'b0;
      r_settle_cnt <= '0;
      r_to_cnt     <= '0;
      r_retry      <= '0;
      r_idx        <= IDX_CTRL;
      r_is64       <= 1'b0;
      r_dwaddr     <= '0;
      r_addr       <= DEF_ADDR;
      r_data       <= DEF_DATA;
      r_mme        <= '0;
      r_error      <= 1'b0;
    end else begin
      r_en_q <= cfg_interrupt_msienable;
      if (!cfg_interrupt_msienable) r_armed <= 1'b1;

      if (w_enter) begin
        r_settle_cnt <= '0;
        r_retry      <= '0;
        r_idx        <= IDX_CTRL;
        r_error      <= 1'b0;
      end else if (r_state == S_SETTLE && r_settle_cnt != SETTLE_LAST) begin
        r_settle_cnt <= r_settle_cnt + 16'd1;
      end

      if (w_next == S_ISSUE) begin
        r_idx    <= w_issue_idx;
        r_dwaddr <= w_issue_addr;
      end

      if (r_state == S_ISSUE)                 r_to_cnt <= '0;
      else if (r_state == S_WAIT && !w_to_term) r_to_cnt <= r_to_cnt + 1'b1;

      if (w_retry) r_retry <= r_retry + 4'd1;
      if (r_state == S_WAIT && w_next == S_ERR) r_error <= 1'b1;

      if (w_capture) begin
        r_retry <= '0;
        case (r_idx)
          IDX_CTRL: begin
            r_mme  <= cfg_do[22:20];
            r_is64 <= cfg_do[23];
          end
          IDX_ALO: begin
            r_addr[31:0] <= cfg_do;
            if (!r_is64) r_addr[63:32] <= '0;
          end
          IDX_AHI: r_addr[63:32] <= cfg_do;
          default: r_data <= cfg_do[15:0];
        endcase
      end
    end
  end

  assign cfg_dwaddr           = r_dwaddr;
  assign cfg_rd_en_n          = (r_state != S_ISSUE);
  assign msi_message_addr_reg = r_addr;
  assign msi_message_data_reg = r_data;
  assign msi_mme              = r_mme;
  assign msi_valid            = (r_state == S_DONE);
  assign msi_busy             = (r_state == S_SETTLE) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign msi_error            = r_error;
endmodule

// File: tb/tb_msi_cfg_reader.sv
// Bench for msi_cfg_reader: vector table plus random runs checked against a timing/value model
// of the capability walk, with hand-made sequences for disable, reset and abort cases.
`timescale 1ns/1ps
module tb_msi_cfg_reader;
  localparam logic [9:0]  BASE = 10'h022;
  localparam int          S    = 256;
  localparam int          TW   = 9;
  localparam int          TMO  = 1 << TW;
  localparam int          MAXR = 3;
  localparam logic [63:0] DEFA = 64'h00000000_FEEFF00C;
  localparam logic [15:0] DEFD = 16'h4162;

  logic        trn_clk = 1'b0;
  logic        reset, en, refresh, cfg_rd_en_n, done_n, valid, busy, err;
  logic [9:0]  cfg_dwaddr;
  logic [31:0] cfg_do;
  logic [63:0] addr;
  logic [15:0] data;
  logic [2:0]  mme;

  always #5 trn_clk = ~trn_clk;

  msi_cfg_reader #(.MSI_CAP_BASE(BASE), .SETTLE_CYCLES(S), .TIMEOUT_W(TW), .MAX_RETRIES(MAXR),
                   .DEF_ADDR(DEFA), .DEF_DATA(DEFD)) dut (
    .trn_clk(trn_clk), .reset(reset), .cfg_interrupt_msienable(en), .refresh(refresh),
    .cfg_dwaddr(cfg_dwaddr), .cfg_rd_en_n(cfg_rd_en_n), .cfg_do(cfg_do),
    .cfg_rd_wr_done_n(done_n), .msi_message_addr_reg(addr), .msi_message_data_reg(data),
    .msi_mme(mme), .msi_valid(valid), .msi_busy(busy), .msi_error(err));

  typedef struct {
    logic [31:0]      ctrl, alo, ahi, dat;
    logic [3:0][9:0]  lat;    // response latency per role CTRL/ALO/AHI/DATA
    logic [3:0][3:0]  nfail;  // leading attempts per role that get no response
    logic [63:0]      e_addr;
    logic [15:0]      e_data;
    logic [2:0]       e_mme;
    logic             e_err;
  } vec_t;

  int          checks = 0, errors = 0;
  logic [63:0] m_addr;
  logic [15:0] m_data;
  logic [2:0]  m_mme;
  logic        m_err;
  logic [9:0]  exp_a[$];
  int          exp_t[$];
  int          exp_end;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic vec_t mkv(input logic [31:0] ctrl, alo, ahi, dat, input int lat,
                               input int srole, input int slat, input int frole, input int nf,
                               input logic [63:0] ea, input logic [15:0] ed,
                               input logic [2:0] em, input logic ee);
    vec_t v;
    v.ctrl = ctrl; v.alo = alo; v.ahi = ahi; v.dat = dat;
    for (int r = 0; r < 4; r++) begin
      v.lat[r]   = 10'(lat);
      v.nfail[r] = 4'd0;
    end
    if (srole >= 0) v.lat[srole] = 10'(slat);
    if (frole >= 0) v.nfail[frole] = 4'(nf);
    v.e_addr = ea; v.e_data = ed; v.e_mme = em; v.e_err = ee;
    return v;
  endfunction

  // Expected strobe addresses/cycles and end cycle from the dword-walk rules; cycle 0 is the start drive.
  task automatic build_model(input vec_t v, input int abort_at);
    logic is64;
    int   roles[$];
    int   t;
    bit   failed;
    is64 = v.ctrl[23];
    exp_a.delete(); exp_t.delete();
    t = S + 1; failed = 0;
    roles.push_back(0); roles.push_back(1);
    if (is64) roles.push_back(2);
    roles.push_back(3);
    for (int i = 0; i < roles.size() && !failed; i++) begin
      int         r;
      logic [9:0] a;
      r = roles[i];
      a = BASE + 10'((r == 3) ? (is64 ? 3 : 2) : r);
      for (int k = 0; k <= MAXR; k++) begin
        if (abort_at == 0 || t < abort_at) begin
          exp_a.push_back(a);
          exp_t.push_back(t);
        end
        if (k < int'(v.nfail[r])) begin
          t += TMO + 1;
          if (k == MAXR) failed = 1;
        end else begin
          if (abort_at == 0 || t + int'(v.lat[r]) < abort_at) begin
            case (r)
              0: m_mme = v.ctrl[22:20];
              1: begin m_addr[31:0] = v.alo; if (!is64) m_addr[63:32] = 32'd0; end
              2: m_addr[63:32] = v.ahi;
              default: m_data = v.dat[15:0];
            endcase
          end
          t += int'(v.lat[r]) + 1;
          break;
        end
      end
    end
    exp_end = t;
    m_err = (abort_at == 0) ? failed : 1'b0;
  endtask

  function automatic logic [31:0] cfg_mem(input vec_t v, input logic [9:0] off);
    case (off)
      10'd0:   return v.ctrl;
      10'd1:   return v.alo;
      10'd2:   return v.ctrl[23] ? v.ahi : v.dat;
      10'd3:   return v.dat;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge trn_clk);
    reset = 1'b1; en = 1'b0; refresh = 1'b0; done_n = 1'b1; cfg_do = 32'd0;
    repeat (3) @(negedge trn_clk);
    reset = 1'b0;
    m_addr = DEFA; m_data = DEFD; m_mme = 3'd0; m_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dwaddr"}, 64'(cfg_dwaddr), 64'd0);
    chk({tag, "_rd_en_n"}, 64'(cfg_rd_en_n), 64'd1);
    chk({tag, "_addr"}, addr, DEFA);
    chk({tag, "_data"}, 64'(data), 64'(DEFD));
    chk({tag, "_mme"}, 64'(mme), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_error"}, 64'(err), 64'd0);
  endtask

  // mode 0: enable low then rising edge; mode 1: refresh pulse with enable held high.
  task automatic run_seq(input vec_t v, input int mode, input int abort_at, input bit use_tbl);
    logic [9:0]  got_a[$];
    int          got_t[$];
    int          c, end_c, resp_at, att, role, budget;
    bit          pend;
    logic [31:0] resp_d;
    logic        prev_err;
    logic [9:0]  off;
    prev_err = m_err;
    if (mode == 0) begin
      @(negedge trn_clk); en = 1'b0;
      @(negedge trn_clk);
      chk("disable_valid", 64'(valid), 64'd0);
      chk("disable_busy", 64'(busy), 64'd0);
      chk("disable_err_kept", 64'(err), 64'(prev_err));
      en = 1'b1;
    end else begin
      @(negedge trn_clk); refresh = 1'b1;
    end
    build_model(v, abort_at);
    c = 0; end_c = -1; pend = 0; resp_at = 0; resp_d = 32'd0;
    budget = S + 4 * (MAXR + 1) * (TMO + 2) + 100;
    while (c < budget) begin
      @(negedge trn_clk);
      c++;
      refresh = (c == S / 2);
      if (c == S / 2) chk("busy_in_settle", 64'(busy), 64'd1);
      if (abort_at != 0 && c == abort_at) en = 1'b0;
      if (abort_at != 0 && c == abort_at + 1) chk("abort_idle_next", 64'(busy), 64'd0);
      if (!cfg_rd_en_n) begin
        att = 0;
        foreach (got_a[i]) if (got_a[i] == cfg_dwaddr) att++;
        got_a.push_back(cfg_dwaddr);
        got_t.push_back(c);
        off = cfg_dwaddr - BASE;
        case (off)
          10'd0: role = 0;
          10'd1: role = 1;
          10'd2: role = v.ctrl[23] ? 2 : 3;
          10'd3: role = 3;
          default: role = -1;
        endcase
        pend = 0;
        if (role >= 0 && att >= int'(v.nfail[role])) begin
          pend    = 1;
          resp_at = c + int'(v.lat[role]);
          resp_d  = cfg_mem(v, off);
        end
      end
      if (pend && c == resp_at) begin
        done_n = 1'b0; cfg_do = resp_d; pend = 0;
      end else begin
        done_n = 1'b1; cfg_do = $urandom;
      end
      if (abort_at == 0 && !busy && (valid || err)) begin
        end_c = c;
        break;
      end
      if (abort_at != 0 && c == abort_at + TMO + 20) break;
    end
    done_n = 1'b1;
    refresh = 1'b0;
    chk("strobe_count", 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      chk("strobe_addr", 64'(got_a[i]), 64'(exp_a[i]));
      chk("strobe_cycle", 64'(got_t[i]), 64'(exp_t[i]));
    end
    if (abort_at != 0) begin
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_valid", 64'(valid), 64'd0);
      chk("abort_err", 64'(err), 64'd0);
    end else begin
      chk("end_cycle", 64'(end_c), 64'(exp_end));
      chk("final_addr", addr, use_tbl ? v.e_addr : m_addr);
      chk("final_data", 64'(data), 64'(use_tbl ? v.e_data : m_data));
      chk("final_mme", 64'(mme), 64'(use_tbl ? v.e_mme : m_mme));
      chk("final_err", 64'(err), 64'(use_tbl ? v.e_err : m_err));
      chk("final_valid", 64'(valid), 64'(use_tbl ? !v.e_err : !m_err));
    end
  endtask

  initial begin
    vec_t v;
    int   nstrobe;
    reset = 1'b1; en = 1'b0; refresh = 1'b0; done_n = 1'b1; cfg_do = 32'd0;
    tbl[0] = mkv(32'h0080_7005, 32'hFEE0_1000, 32'h0000_0001, 32'h0000_4020, 3, -1, 0, -1, 0,
                 64'h00000001_FEE01000, 16'h4020, 3'd0, 1'b0);
    tbl[1] = mkv(32'h0030_7005, 32'hFEE0_2000, 32'h5555_5555, 32'hABCD_1234, 4, -1, 0, -1, 0,
                 64'h00000000_FEE02000, 16'h1234, 3'd3, 1'b0);
    tbl[2] = mkv(32'h0080_7005, 32'hFEE0_1000, 32'h0000_0001, 32'h0000_4020, 2, -1, 0, 1, 4,
                 DEFA, DEFD, 3'd0, 1'b1);
    tbl[3] = mkv(32'h00F0_0000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_BEEF, 2, 3, TMO, -1, 0,
                 64'h9ABCDEF0_12345678, 16'hBEEF, 3'd7, 1'b0);
    tbl[4] = mkv(32'h0010_0000, 32'hCAFE_0000, 32'h1111_1111, 32'h0000_0042, 5, -1, 0, 1, 2,
                 64'h00000000_CAFE0000, 16'h0042, 3'd1, 1'b0);
    tbl[5] = mkv(32'h0050_0000, 32'h8765_4321, 32'h2222_2222, 32'h0000_7777, 3, -1, 0, 3, 9,
                 64'h00000000_87654321, DEFD, 3'd5, 1'b1);

    do_reset();
    @(negedge trn_clk);
    check_reset_vals("reset");

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_seq(tbl[i], 0, 0, 1);
    end

    // Reset during SETTLE with enable held high afterwards: no reads until enable toggles.
    @(negedge trn_clk); en = 1'b0;
    @(negedge trn_clk); en = 1'b1;
    repeat (10) @(negedge trn_clk);
    chk("settle_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    @(negedge trn_clk); reset = 1'b0;
    m_addr = DEFA; m_data = DEFD; m_mme = 3'd0; m_err = 1'b0;
    nstrobe = 0;
    for (int i = 0; i < S + 40; i++) begin
      @(negedge trn_clk);
      if (!cfg_rd_en_n) nstrobe++;
    end
    chk("no_strobe_after_reset", 64'(nstrobe), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    run_seq(tbl[0], 0, 0, 1);

    // Enable drops while waiting on AHI, then a fresh edge runs the whole walk.
    v = mkv(32'h0080_0000, 32'hAAAA_0000, 32'h0000_0003, 32'h0000_1357, 2, -1, 0, 2, 15,
            64'h0, 16'h0, 3'd0, 1'b0);
    run_seq(v, 0, S + 10, 0);
    v.nfail[2] = 4'd0;
    run_seq(v, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      v.ctrl = $urandom; v.alo = $urandom; v.ahi = $urandom; v.dat = $urandom;
      for (int r = 0; r < 4; r++) begin
        v.lat[r]   = ($urandom_range(0, 7) == 0) ? 10'(TMO) : 10'($urandom_range(1, 12));
        v.nfail[r] = 4'd0;
      end
      if ($urandom_range(0, 4) == 0) v.nfail[$urandom_range(0, 3)] = 4'($urandom_range(1, 4));
      run_seq(v, int'($urandom_range(0, 1)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/msi_cfg_reader.md
MSI_CFG_READER -- requirements
Module: msi_cfg_reader

Interface
REQ-001 Parameter MSI_CAP_BASE, 10'h022, dword address of the MSI capability header (Cap ID/Next/Message Control).
REQ-002 Parameter SETTLE_CYCLES, 256, idle cycles after enable before the first config read (1..65535).
REQ-003 Parameter TIMEOUT_W, 9, width of the per-read timeout counter; terminal count is all-ones.
REQ-004 Parameter MAX_RETRIES, 3, reissues allowed per dword before error (0..15).
REQ-005 Parameter DEF_ADDR, 64'h00000000_FEEFF00C, reset/default message address.
REQ-006 Parameter DEF_DATA, 16'h4162, reset/default message data.
REQ-007 trn_clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 cfg_interrupt_msienable  in  1  MSI enable from the PCIe core.
REQ-010 refresh  in  1  single-cycle request to re-read the capability.
REQ-011 cfg_dwaddr  out  10  config-space dword address.
REQ-012 cfg_rd_en_n  out  1  active-low config read strobe.
REQ-013 cfg_do  in  32  config read data.
REQ-014 cfg_rd_wr_done_n  in  1  active-low read completion.
REQ-015 msi_message_addr_reg  out  64  captured message address.
REQ-016 msi_message_data_reg  out  16  captured message data.
REQ-017 msi_mme  out  3  Multiple Message Enable field (Message Control bits [6:4], i.e. cfg_do[22:20]).
REQ-018 msi_valid  out  1  address/data/mme reflect a completed read sequence.
REQ-019 msi_busy  out  1  read sequence in progress (any state other than IDLE/DONE/ERR).
REQ-020 msi_error  out  1  a dword exhausted its retries.

Function
REQ-021 States SHALL be IDLE, SETTLE, ISSUE, WAIT, DONE, ERR; ISSUE/WAIT iterate over the dword list, tracked by a dword index.
REQ-022 Dword list SHALL be: CTRL (MSI_CAP_BASE), ALO (+1), then if 64-bit capable (CTRL cfg_do[23]=1) AHI (+2) and DATA (+3), else DATA (+2) with address [63:32] written 0.
REQ-023 IDLE -> SETTLE on a rising edge of cfg_interrupt_msienable (sampled against its registered previous value) or on refresh while cfg_interrupt_msienable=1.
REQ-024 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then enter ISSUE for dword CTRL with retry count 0.
REQ-025 ISSUE SHALL drive cfg_dwaddr to the current dword address and cfg_rd_en_n=0 for exactly one cycle, clear the timeout counter, and go to WAIT; cfg_rd_en_n SHALL be 1 in every other state.
REQ-026 cfg_dwaddr SHALL hold its last value outside ISSUE.
REQ-027 In WAIT, cfg_rd_wr_done_n=0 SHALL capture cfg_do into the target field (CTRL: msi_mme and 64-bit flag; ALO: addr[31:0]; AHI: addr[63:32]; DATA: data <= cfg_do[15:0]), reset retry count, and advance to ISSUE of the next dword, or DONE after DATA.
REQ-028 In WAIT, timeout counter increments each cycle; at all-ones without done: retry count < MAX_RETRIES -> retry count +1, ISSUE same dword; else -> ERR.
REQ-029 Done and timeout terminal count in the same cycle: done SHALL win.
REQ-030 Done asserted outside WAIT SHALL be ignored.
REQ-031 msi_valid SHALL be 0 from entry to SETTLE until the cycle after DATA capture, when it goes 1 with DONE.
REQ-032 ERR SHALL set msi_error=1, msi_valid=0; address/data retain the last captured or default values.
REQ-033 From DONE or ERR, refresh (with enable=1) or a new enable rising edge SHALL restart at SETTLE and clear msi_error.
REQ-034 refresh while msi_busy=1 SHALL be ignored.
REQ-035 cfg_interrupt_msienable=0 in any state SHALL force IDLE next cycle, msi_valid=0, cfg_rd_en_n=1; msi_error and captured values retained.
REQ-036 Counters SHALL saturate/clear per state; no wrap shall cause a spurious transition.

Reset
REQ-037 On reset: state IDLE, cfg_dwaddr=0, cfg_rd_en_n=1, addr=DEF_ADDR, data=DEF_DATA, msi_mme=0, msi_valid=0, msi_busy=0, msi_error=0, all counters 0, registered enable=0.
REQ-038 Reset asserted mid-sequence SHALL abort immediately to the reset values; no read strobe after reset release until a new enable edge.

Verification
REQ-039 64-bit: enable rises, reads return CTRL 32'h0080_7005 (bit23=1, MME=0), 32'hFEE0_1000, 32'h0000_0001, 32'h0000_4020 -> strobes at 10'h022..025, addr=64'h00000001_FEE01000, data=16'h4020, msi_valid=1.
REQ-040 32-bit: CTRL 32'h0030_7005 (bit23=0, MME=3) -> reads 10'h022, 023, 024 only; addr[63:32]=0, msi_mme=3.
REQ-041 Timeout: no done for ALO with MAX_RETRIES=3 -> 4 strobes to 10'h023 spaced 2^TIMEOUT_W+1 cycles, then msi_error=1, msi_valid=0, addr=DEF_ADDR.
REQ-042 Enable drops during WAIT of AHI -> IDLE next cycle, no further strobes; enable re-rises -> full sequence restarts after SETTLE_CYCLES.
REQ-043 Done coincident with timeout terminal count -> data captured, no retry strobe; refresh during busy -> no restart.
REQ-044 Reset asserted during SETTLE -> all outputs to REQ-037 values; enable held high after release -> no reads until enable toggles.
